muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the execute stage, complementing the single-cycle ALU for the M-extension operations. It accepts a request from the issue logic and holds the pipeline via `busy`. It computes with a radix-2 shift-add / restoring-divide datapath over 32 iterations, then returns a registered 32-bit result with a one-cycle `done` strobe. It is the multi-cycle responder the hazard/stall logic talks to.

---
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, with a registered result and a one-cycle done strobe.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs1F,
  input  logic [WIDTH-1:0] rs2F,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic               neg_q, neg_rem_q, special_q, done_q;

  // Request decode, only consumed on the accepting edge.
  logic             sgn1, sgn2, neg1, neg2, div_zero, ovf, neg_in;
  logic [WIDTH-1:0] abs1, abs2, spec_val;

  always_comb begin
    sgn1     = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    sgn2     = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    neg1     = sgn1 & rs1F[WIDTH-1];
    neg2     = sgn2 & rs2F[WIDTH-1];
    abs1     = neg1 ? -rs1F : rs1F;
    abs2     = neg2 ? -rs2F : rs2F;
    div_zero = op[2] && (rs2F == '0);
    ovf      = op[2] && !op[0] && (rs1F == MinNeg) && (rs2F == '1);
    if (div_zero) spec_val = op[1] ? rs1F : '1;
    else          spec_val = op[1] ? '0 : MinNeg;
    if (op[2]) neg_in = neg1 ^ neg2;
    else       neg_in = (neg1 ^ neg2) && (rs1F != '0) && (rs2F != '0);
  end

  // One iteration of each datapath.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   div_sub, quot, rem, fix_val;
  logic               div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    // Shifted remainder is WIDTH+1 bits wide; when it is >= divisor the
    // difference always fits back into WIDTH bits.
    div_ge   = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, b_q};
    div_sub  = acc_q[2*WIDTH-2:WIDTH-1] - b_q;
    div_next = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};
    prod     = neg_q ? -acc_q : acc_q;
    quot     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem      = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (op_q[2])           fix_val = op_q[1] ? rem : quot;
    else if (op_q == 3'd0) fix_val = prod[WIDTH-1:0];
    else                   fix_val = prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q      <= op;
            a_q       <= abs1;
            b_q       <= abs2;
            cnt_q     <= '0;
            neg_q     <= neg_in;
            neg_rem_q <= op[2] & neg1;
            special_q <= div_zero | ovf;
            if (div_zero || ovf) acc_q <= {{WIDTH{1'b0}}, spec_val};
            else                 acc_q <= {{WIDTH{1'b0}}, (op[2] ? abs1 : '0)};
            state_q   <= StCalc;
          end
        end
        StCalc: begin
          if (special_q) begin
            result_q <= acc_q[WIDTH-1:0];
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else if (cnt_q == CntW'(WIDTH)) begin
            state_q <= StFix;
          end else begin
            acc_q <= op_q[2] ? div_next : mul_next;
            b_q   <= op_q[2] ? b_q : (b_q >> 1);
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFix: begin
          result_q <= fix_val;
          done_q   <= 1'b1;
          state_q  <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected result and latency;
// a monitor pops and checks on every done strobe.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs1F = '0, rs2F = '0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .nRst(nRst), .start(start), .op(op), .rs1F(rs1F), .rs2F(rs2F),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    int          t0;
    int          lat;
    string       name;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on each done and checks the strobe is one cycle wide.
  initial begin
    logic prev_done = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_done) chk("done_single_cycle", {31'd0, done}, 32'd0);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: result=%h with no op pending", result);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.exp);
          chk({e.name, "_latency"}, cyc - e.t0 - 1, e.lat);
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string nm, input bit push);
    wait_idle();
    start = 1'b1;
    op    = o;
    rs1F  = a;
    rs2F  = b;
    if (push) sb.push_back('{exp: exp, t0: cyc, lat: lat, name: nm});
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_7_m3"};
    vecs[1]  = '{3'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34, "mulh_7_m3"};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu_ff"};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu_ff"};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "div_m7_2"};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "rem_m7_2"};
    vecs[6]  = '{3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34, "divu_m7_2"};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        34, "remu_100_7"};
    vecs[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div_by_zero"};
    vecs[9]  = '{3'd7, 32'd5,        32'd0,        32'd5,        1,  "remu_by_zero"};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf"};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf"};
    vecs[12] = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul_before_flush"};

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    nRst = 1'b1;

    foreach (vecs[i])
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name, 1'b1);

    // Flush a DIVU 100/3 at E10; result must keep the previous MUL value.
    issue(3'd5, 32'd100, 32'd3, 32'd33, 34, "divu_flushed", 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_result_hold", result, 32'hFFFFFFEB);
    issue(3'd0, 32'd6, 32'd7, 32'd42, 34, "mul_6_7", 1'b1);

    // Asynchronous reset mid-CALC clears outputs and discards the op.
    issue(3'd3, 32'h12345678, 32'h9ABCDEF0, 32'd0, 34, "mulhu_reset", 1'b0);
    repeat (5) @(negedge clk);
    nRst = 1'b0;
    #1;
    chk("midop_reset_busy", {31'd0, busy}, 32'd0);
    chk("midop_reset_done", {31'd0, done}, 32'd0);
    chk("midop_reset_result", result, 32'd0);
    @(negedge clk);
    nRst = 1'b1;

    // A second start during CALC must be ignored.
    issue(3'd0, 32'd3, 32'd4, 32'd12, 34, "mul_3_4", 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    rs1F  = 32'd5;
    rs2F  = 32'd5;
    @(negedge clk);
    start = 1'b0;

    wait_idle();
    repeat (60) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
